// File: rtl/avl_slave_ram_responder_pkg.sv
// Shared bus types for the Avalon-style RAM responder: data/byte-enable widths
// and the response record carried down the read-latency pipeline.
package avl_bus_type;

  localparam int AVL_DATA_W = 32;
  localparam int AVL_BE_W   = 4;

  typedef struct packed {
    logic [AVL_DATA_W-1:0] data;
    logic                  valid;
  } avl_resp_t;

endpackage

// File: rtl/avl_slave_ram_responder_fifo.sv
// First-word-fall-through response FIFO. The head is visible while the FIFO is not empty.
// There is no overflow protection because the credit counter upstream bounds occupancy.
module avl_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok = pop && (cnt != '0);
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop_ok)      cnt <= cnt + CNT_W'(1);
      else if (!push && pop_ok) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/avl_slave_ram_responder.sv
// Avalon-style slave: byte-enabled word RAM, fixed-latency in-order read responses,
// with credit-limited outstanding reads that are absorbed by a FWFT response FIFO.
module avl_slave_ram_responder
  import avl_bus_type::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           address,
  input  logic [AVL_BE_W-1:0]   byte_en,
  input  logic [AVL_DATA_W-1:0] write_data,
  output logic                  request_ready,
  output logic [AVL_DATA_W-1:0] read_data,
  output logic                  read_data_valid,
  input  logic                  resp_ready,
  output logic                  proto_err
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [AVL_DATA_W-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  unused_addr_bits;
  logic                  accept;
  logic                  acc_read;
  logic                  acc_write;
  logic                  handshake;
  logic [CNT_W-1:0]      outstanding;
  avl_resp_t             acc_ent;
  avl_resp_t             push_ent;
  logic [AVL_DATA_W-1:0] fifo_head;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  assign word_addr        = address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], address[1:0]};

  assign request_ready = !rest && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept        = request_ready && (read || write);
  // A simultaneous read+write performs the write and drops the read.
  assign acc_write     = accept && write;
  assign acc_read      = accept && read && !write;
  assign handshake     = read_data_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (acc_write) begin
      for (int k = 0; k < AVL_BE_W; k++) begin
        if (byte_en[k]) mem[word_addr][8*k +: 8] <= write_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    acc_ent       = '0;
    acc_ent.valid = acc_read;
    acc_ent.data  = mem[word_addr];
  end

  // Stage 0 is captured on the accepting edge; the FIFO push adds the final cycle.
  if (READ_LATENCY == 1) begin : g_direct
    assign push_ent = acc_ent;
  end else begin : g_pipe
    avl_resp_t stage_q [READ_LATENCY-1];

    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= acc_ent;
        for (int i = 1; i < READ_LATENCY - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign push_ent = stage_q[READ_LATENCY-2];
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      outstanding <= '0;
    end else if (acc_read && !handshake) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!acc_read && handshake) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest)                        proto_err <= 1'b0;
    else if (accept && read && write) proto_err <= 1'b1;
  end

  avl_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (AVL_DATA_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rest      (rest),
    .push      (push_ent.valid),
    .push_data (push_ent.data),
    .pop       (handshake),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign read_data_valid = (fifo_count != '0);
  assign read_data       = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_avl_slave_ram_responder.sv
// Directed bench for avl_slave_ram_responder at default parameters (latency 2, depth 4).
module tb_avl_slave_ram_responder;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] write_data = '0;
  logic        resp_ready = 1'b0;
  logic        request_ready;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  avl_slave_ram_responder #(
    .ADDR_WIDTH   (10),
    .READ_LATENCY (2),
    .RESP_DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rest            (rest),
    .read            (read),
    .write           (write),
    .address         (address),
    .byte_en         (byte_en),
    .write_data      (write_data),
    .request_ready   (request_ready),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .resp_ready      (resp_ready),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    read       = rd;
    write      = wr;
    address    = addr;
    byte_en    = be;
    write_data = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles_no_valid(input int n, input string name);
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {31'b0, read_data_valid}, 32'h0);
      next_cycle();
    end
  endtask

  initial begin
    int accepts;

    vecs[0]  = '{1'b0, 1'b1, 32'h10, 4'hF, 32'hAABBCCDD, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h10, 4'h5, 32'h11223344, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h10, 4'h0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 32'hAA22CC44};
    vecs[5]  = '{1'b0, 1'b1, 32'h20, 4'hF, 32'h5,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h20, 4'h0, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h20, 4'hF, 32'h9,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h20, 4'h0, 32'h0,        1'b1, 32'h5};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b1, 32'h9};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 32'h0};

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_request_ready", {31'b0, request_ready}, 32'h0);
      check("reset_valid", {31'b0, read_data_valid}, 32'h0);
      check("reset_data", read_data, 32'h0);
      check("reset_proto_err", {31'b0, proto_err}, 32'h0);
    end
    next_cycle();
    rest = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, request_ready}, 32'h1);

    // Byte lanes, read-after-write, ordering
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].be, vecs[v].wd);
      @(negedge clk);
      check($sformatf("vec%0d_valid", v), {31'b0, read_data_valid}, {31'b0, vecs[v].exp_valid});
      check($sformatf("vec%0d_data", v), read_data, vecs[v].exp_data);
      check($sformatf("vec%0d_ready", v), {31'b0, request_ready}, 32'h1);
      next_cycle();
    end

    // Preload words 0..15 with their index
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(4 * i), 4'hF, 32'(i));
      next_cycle();
    end

    // Streaming: 16 back-to-back reads, no bubbles
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1'b1, 1'b0, 32'(4 * c), 4'h0, '0);
      else        drive(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      if (c < 16) check($sformatf("stream_ready%0d", c), {31'b0, request_ready}, 32'h1);
      check($sformatf("stream_valid%0d", c), {31'b0, read_data_valid}, (c >= 2) ? 32'h1 : 32'h0);
      check($sformatf("stream_data%0d", c), read_data, (c >= 2) ? 32'(c - 2) : 32'h0);
      next_cycle();
    end
    idle_cycles_no_valid(1, "stream_tail_valid");

    // Credit stall with resp_ready low
    resp_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 32'(4 * c), 4'h0, '0);
      @(negedge clk);
      if (request_ready) accepts++;
      if (c >= 2) begin
        check($sformatf("stall_valid%0d", c), {31'b0, read_data_valid}, 32'h1);
        check($sformatf("stall_data%0d", c), read_data, 32'h0);
      end
      if (c >= 4) check($sformatf("stall_ready%0d", c), {31'b0, request_ready}, 32'h0);
      next_cycle();
    end
    check("stall_accepts", 32'(accepts), 32'd4);
    drive(1'b0, 1'b0, '0, '0, '0);
    resp_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      check($sformatf("drain_valid%0d", r), {31'b0, read_data_valid}, 32'h1);
      check($sformatf("drain_data%0d", r), read_data, 32'(r));
      check($sformatf("drain_ready%0d", r), {31'b0, request_ready}, (r == 0) ? 32'h0 : 32'h1);
      next_cycle();
    end
    idle_cycles_no_valid(2, "drain_tail_valid");

    // Protocol error: simultaneous read and write
    check("proto_err_clear", {31'b0, proto_err}, 32'h0);
    drive(1'b1, 1'b1, 32'h8, 4'hF, 32'h7);
    @(negedge clk);
    check("proto_ready", {31'b0, request_ready}, 32'h1);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("proto_no_resp%0d", i), {31'b0, read_data_valid}, 32'h0);
      check($sformatf("proto_sticky%0d", i), {31'b0, proto_err}, 32'h1);
      next_cycle();
    end
    drive(1'b1, 1'b0, 32'h8, 4'h0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    @(negedge clk);
    check("proto_word_valid", {31'b0, read_data_valid}, 32'h1);
    check("proto_word_data", read_data, 32'h7);
    next_cycle();

    // Reset mid-burst with 3 reads outstanding
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 32'(4 * c), 4'h0, '0);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    check("pre_reset_valid", {31'b0, read_data_valid}, 32'h1);
    rest = 1'b1;
    #1;
    check("mid_reset_valid", {31'b0, read_data_valid}, 32'h0);
    check("mid_reset_data", read_data, 32'h0);
    check("mid_reset_ready", {31'b0, request_ready}, 32'h0);
    check("mid_reset_proto_err", {31'b0, proto_err}, 32'h0);
    next_cycle();
    rest = 1'b0;
    #1;
    check("post_reset_ready", {31'b0, request_ready}, 32'h1);
    resp_ready = 1'b1;
    idle_cycles_no_valid(4, "post_reset_no_stale");
    resp_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 32'(4 * c), 4'h0, '0);
      @(negedge clk);
      if (request_ready) accepts++;
      next_cycle();
    end
    check("post_reset_credits", 32'(accepts), 32'd4);
    drive(1'b0, 1'b0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avl_slave_ram_responder.md
# avl_slave_ram_responder

Synthesizable Avalon-style slave. It terminates one `i_avl_bus` master port with a word-addressed byte-enabled RAM, and returns read data in order through a fixed-latency pipeline. A credit-limited response FIFO absorbs master back-pressure. It is the responder end of the bus that the monitor model checks, so the monitor's expected-value queue must match its output exactly.

## Interface
- `ADDR_WIDTH`, default 10: number of word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words.
- `READ_LATENCY`, default 2: cycles from read acceptance to earliest `read_data_valid`. Legal range 1..8.
- `RESP_DEPTH`, default 4: maximum outstanding reads, counting both the pipeline and the FIFO. Must be >= `READ_LATENCY`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rest` in 1: asynchronous, active-high reset.
- `read` in 1: read request.
- `write` in 1: write request.
- `address` in 32: byte address. Bits [ADDR_WIDTH+1:2] select the word; all other bits are ignored.
- `byte_en` in 4: write byte lanes, bit k covers `write_data[8k+7:8k]`.
- `write_data` in 32: write data.
- `request_ready` out 1: command accepted in this cycle if `read` or `write` is high.
- `read_data` out 32: response data, valid only with `read_data_valid`.
- `read_data_valid` out 1: response present.
- `resp_ready` in 1: master consumes the response in this cycle.
- `proto_err` out 1: sticky flag, set when `read` and `write` are both high in an accepted cycle.

## Operation
- **Accept.** A command is accepted on any edge where `request_ready` is high and `read` or `write` is high.
- **Write.**
  - Each enabled byte lane updates on the accepting edge. Disabled lanes keep their old value.
  - Writes consume no credit and produce no response.
- **Read.**
  - The RAM word is sampled at the accepting edge and carried down a `READ_LATENCY`-deep pipeline into the response FIFO.
  - Because sampling happens at acceptance, a write accepted in the next cycle does not alter a read already in flight.
- **Read-after-write.** Write in cycle N, read of the same word in cycle N+1: the read returns the new data.
- **Read and write in the same accepted cycle.**
  - This is illegal.
  - The write is performed and the read is dropped: no credit is taken and no response is produced.
  - `proto_err` sets and stays set until reset.
- **Credits.**
  - `outstanding` counter, 0..RESP_DEPTH.
  - +1 on each accepted read.
  - −1 on each response handshake (`read_data_valid && resp_ready`).
  - Both in the same cycle leave it unchanged.
  - `request_ready = !rest && outstanding < RESP_DEPTH`. It also gates writes, which keeps command ordering simple.
- **FIFO.**
  - First-word-fall-through.
  - `read_data_valid` = FIFO not empty.
  - `read_data` = FIFO head.
  - Responses leave in acceptance order.
  - The credit scheme guarantees the FIFO never overflows, so there is no full-drop path.
- **Reset.**
  - Outputs during and after reset: `request_ready`=0 while `rest` is high, `read_data_valid`=0, `read_data`=0, `proto_err`=0. Counter and FIFO pointers clear.
  - In-flight pipeline entries are discarded.
  - RAM contents are not reset and are undefined after power-up.
  - Reset asserted mid-burst loses all pending responses. No response is emitted after reset deassertion unless a new read is accepted.

## Timing
- Read accepted in cycle N, FIFO empty, `resp_ready` high: `read_data_valid` is high in cycle N+READ_LATENCY and the handshake completes in that cycle.
- Back-to-back reads each cycle with `resp_ready` held high sustain one response per cycle whenever `RESP_DEPTH` > `READ_LATENCY`. If `RESP_DEPTH` = `READ_LATENCY`, throughput drops by the credit round trip.
- With `resp_ready` low, `read_data`/`read_data_valid` hold stable until the handshake.
- `request_ready` falls in the cycle after the counter reaches `RESP_DEPTH`. It rises in the cycle after the freeing handshake; there is no same-cycle credit bypass.
- `request_ready` is high in the first cycle after `rest` falls.

## Structure
- Shared package `avl_bus_type` gets `AVL_DATA_W=32`, `AVL_BE_W=4`, and `avl_resp_t` (`data`, `valid`) for the pipeline stages.
- Sub-module `avl_resp_fifo`: parameterised first-word-fall-through FIFO of depth `RESP_DEPTH`. It has push, pop, head, empty and count, and the same `clk`/`rest`.
- The top level holds the RAM, the write-lane logic, the latency shift register, the credit counter and `proto_err`.

## Test plan
- **Byte-lane write:** write `0xAABBCCDD` be=F to 0x10, then write `0x11223344` be=5 to 0x10, then read 0x10 → `0xAA22CC44`, valid exactly READ_LATENCY cycles after acceptance.
- **Credit stall:** `resp_ready` held 0, read issued every cycle → exactly 4 accepts, then `request_ready`=0. Raise `resp_ready` → 4 responses in order, and `request_ready` returns one cycle after the first handshake.
- **Streaming:** `RESP_DEPTH`=4, `READ_LATENCY`=2, 16 back-to-back reads of addresses 0x0..0x3C preloaded with index values → 16 consecutive valid cycles returning 0..15, no bubbles.
- **Ordering:** read 0x20 (holding 5) in cycle N, write 9 to 0x20 in cycle N+1 → response is 5. A following read returns 9.
- **Protocol error:** `read`=`write`=1 to 0x8 with data 7 → word 0x8 = 7, no response, `proto_err`=1 until reset.
- **Reset mid-burst:** 3 reads outstanding, assert `rest` for 1 cycle → `read_data_valid`=0 immediately and `request_ready`=0 during reset. After deassertion, no stale response and a full 4 credits are available.
